// File: rtl/speicher_arbiter.sv
// Round-robin arbiter sharing one memory bus between instruction fetch and data load/store.
// One transaction at a time; a grant lasts until SpeicherBereit or timeout, then a one-cycle done state.
module speicher_arbiter #(
  parameter int ADRESS_BREITE = 32,
  parameter int DATEN_BREITE  = 32,
  parameter int TIMEOUT       = 255
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     BefehlAnfrage,
  input  logic [ADRESS_BREITE-1:0] BefehlAdresse,
  output logic [DATEN_BREITE-1:0]  Befehl,
  output logic                     BefehlGeladen,
  input  logic                     DatenLesen,
  input  logic                     DatenSchreiben,
  input  logic [ADRESS_BREITE-1:0] DatenAdresse,
  input  logic [DATEN_BREITE-1:0]  DatenSchreibwert,
  output logic [DATEN_BREITE-1:0]  DatenLesewert,
  output logic                     DatenGeladen,
  output logic                     DatenGespeichert,
  output logic [ADRESS_BREITE-1:0] SpeicherAdresse,
  output logic [DATEN_BREITE-1:0]  SpeicherSchreibwert,
  output logic                     SpeicherLesen,
  output logic                     SpeicherSchreiben,
  input  logic [DATEN_BREITE-1:0]  SpeicherLesewert,
  input  logic                     SpeicherBereit,
  output logic                     Zeitfehler
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TMAX  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TMAX);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {IDLE, BEFEHL, LESEN, SCHREIBEN, ABSCHLUSS} state_t;
  typedef enum logic [1:0] {SRC_BEFEHL, SRC_LESEN, SRC_SCHREIBEN} src_t;

  state_t                   state_q, state_d;
  src_t                     src_q, src_d;
  logic                     last_daten_q, last_daten_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [ADRESS_BREITE-1:0] adr_q, adr_d;
  logic [DATEN_BREITE-1:0]  wdat_q, wdat_d;
  logic [DATEN_BREITE-1:0]  befehl_q, befehl_d;
  logic [DATEN_BREITE-1:0]  lese_q, lese_d;
  logic                     zeitfehler_q, zeitfehler_d;

  logic dat_req;
  logic grant_befehl;
  logic grant_daten;

  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    last_daten_d = last_daten_q;
    cnt_d        = cnt_q;
    adr_d        = adr_q;
    wdat_d       = wdat_q;
    befehl_d     = befehl_q;
    lese_d       = lese_q;
    zeitfehler_d = zeitfehler_q;

    // On a tie the port that did not win last time gets the bus.
    dat_req      = DatenLesen | DatenSchreiben;
    grant_befehl = BefehlAnfrage & (~dat_req | last_daten_q);
    grant_daten  = dat_req & ~grant_befehl;

    case (state_q)
      IDLE: begin
        if (grant_befehl | grant_daten) begin
          adr_d        = grant_befehl ? BefehlAdresse : DatenAdresse;
          wdat_d       = DatenSchreibwert;
          cnt_d        = '0;
          last_daten_d = grant_daten;
        end
        if (grant_befehl) begin
          state_d = BEFEHL;
          src_d   = SRC_BEFEHL;
        end else if (grant_daten && DatenSchreiben) begin
          state_d = SCHREIBEN;
          src_d   = SRC_SCHREIBEN;
        end else if (grant_daten) begin
          state_d = LESEN;
          src_d   = SRC_LESEN;
        end
      end
      BEFEHL, LESEN, SCHREIBEN: begin
        if (SpeicherBereit) begin
          state_d = ABSCHLUSS;
          if (state_q == BEFEHL) befehl_d = SpeicherLesewert;
          if (state_q == LESEN)  lese_d   = SpeicherLesewert;
        end else if ((TIMEOUT > 0) && (cnt_q == CNT_LAST)) begin
          // Abort: the requester still gets its done pulse, with a zero read value.
          state_d      = ABSCHLUSS;
          zeitfehler_d = 1'b1;
          if (state_q == BEFEHL) befehl_d = '0;
          if (state_q == LESEN)  lese_d   = '0;
        end else if (TIMEOUT > 0) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ABSCHLUSS: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q      <= IDLE;
      src_q        <= SRC_BEFEHL;
      last_daten_q <= 1'b1;
      cnt_q        <= '0;
      adr_q        <= '0;
      wdat_q       <= '0;
      befehl_q     <= '0;
      lese_q       <= '0;
      zeitfehler_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      last_daten_q <= last_daten_d;
      cnt_q        <= cnt_d;
      adr_q        <= adr_d;
      wdat_q       <= wdat_d;
      befehl_q     <= befehl_d;
      lese_q       <= lese_d;
      zeitfehler_q <= zeitfehler_d;
    end
  end

  // Strobes and done pulses decode the state flop, so an async reset kills them at once.
  assign SpeicherLesen       = (state_q == BEFEHL) || (state_q == LESEN);
  assign SpeicherSchreiben   = (state_q == SCHREIBEN);
  assign BefehlGeladen       = (state_q == ABSCHLUSS) && (src_q == SRC_BEFEHL);
  assign DatenGeladen        = (state_q == ABSCHLUSS) && (src_q == SRC_LESEN);
  assign DatenGespeichert    = (state_q == ABSCHLUSS) && (src_q == SRC_SCHREIBEN);
  assign SpeicherAdresse     = adr_q;
  assign SpeicherSchreibwert = wdat_q;
  assign Befehl              = befehl_q;
  assign DatenLesewert       = lese_q;
  assign Zeitfehler          = zeitfehler_q;

endmodule

// File: tb/tb_speicher_arbiter.sv
// Self-checking bench for speicher_arbiter: transaction-level reference model plus directed scenarios.
module tb_speicher_arbiter;

  localparam int TO = 4;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        BefehlAnfrage = 1'b0;
  logic [31:0] BefehlAdresse = '0;
  logic [31:0] Befehl;
  logic        BefehlGeladen;
  logic        DatenLesen = 1'b0;
  logic        DatenSchreiben = 1'b0;
  logic [31:0] DatenAdresse = '0;
  logic [31:0] DatenSchreibwert = '0;
  logic [31:0] DatenLesewert;
  logic        DatenGeladen;
  logic        DatenGespeichert;
  logic [31:0] SpeicherAdresse;
  logic [31:0] SpeicherSchreibwert;
  logic        SpeicherLesen;
  logic        SpeicherSchreiben;
  logic [31:0] SpeicherLesewert = '0;
  logic        SpeicherBereit = 1'b0;
  logic        Zeitfehler;

  speicher_arbiter #(.ADRESS_BREITE(32), .DATEN_BREITE(32), .TIMEOUT(TO)) dut (
    .Clock(Clock), .Reset(Reset),
    .BefehlAnfrage(BefehlAnfrage), .BefehlAdresse(BefehlAdresse),
    .Befehl(Befehl), .BefehlGeladen(BefehlGeladen),
    .DatenLesen(DatenLesen), .DatenSchreiben(DatenSchreiben),
    .DatenAdresse(DatenAdresse), .DatenSchreibwert(DatenSchreibwert),
    .DatenLesewert(DatenLesewert), .DatenGeladen(DatenGeladen),
    .DatenGespeichert(DatenGespeichert),
    .SpeicherAdresse(SpeicherAdresse), .SpeicherSchreibwert(SpeicherSchreibwert),
    .SpeicherLesen(SpeicherLesen), .SpeicherSchreiben(SpeicherSchreiben),
    .SpeicherLesewert(SpeicherLesewert), .SpeicherBereit(SpeicherBereit),
    .Zeitfehler(Zeitfehler)
  );

  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: which transaction is in flight, how long it has waited, and whether it is finishing.
  typedef enum int {K_NONE, K_FETCH, K_LOAD, K_STORE} kind_e;
  kind_e       m_kind = K_NONE;
  bit          m_fin = 1'b0;
  int          m_wait = 0;
  bit          m_last_data = 1'b1;
  logic [31:0] m_adr = '0, m_wd = '0, m_befehl = '0, m_lese = '0;
  bit          m_zeit = 1'b0;

  always @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      m_kind = K_NONE; m_fin = 0; m_wait = 0; m_last_data = 1;
      m_adr = '0; m_wd = '0; m_befehl = '0; m_lese = '0; m_zeit = 0;
    end else if (m_fin) begin
      m_kind = K_NONE;
      m_fin  = 0;
    end else if (m_kind != K_NONE) begin
      if (SpeicherBereit) begin
        if (m_kind == K_FETCH) m_befehl = SpeicherLesewert;
        if (m_kind == K_LOAD)  m_lese   = SpeicherLesewert;
        m_fin = 1;
      end else begin
        m_wait++;
        if (TO > 0 && m_wait == TO) begin
          if (m_kind == K_FETCH) m_befehl = '0;
          if (m_kind == K_LOAD)  m_lese   = '0;
          m_zeit = 1;
          m_fin  = 1;
        end
      end
    end else begin
      if (BefehlAnfrage && (!(DatenLesen || DatenSchreiben) || m_last_data)) begin
        m_kind = K_FETCH; m_adr = BefehlAdresse; m_last_data = 0; m_wait = 0;
      end else if (DatenLesen || DatenSchreiben) begin
        m_kind = DatenSchreiben ? K_STORE : K_LOAD;
        m_adr = DatenAdresse; m_last_data = 1; m_wait = 0;
        if (DatenSchreiben) m_wd = DatenSchreibwert;
      end
    end
  end

  always @(negedge Clock) begin
    check("strobe_rd", SpeicherLesen, (m_kind == K_FETCH || m_kind == K_LOAD) && !m_fin);
    check("strobe_wr", SpeicherSchreiben, m_kind == K_STORE && !m_fin);
    check("done_befehl", BefehlGeladen, m_kind == K_FETCH && m_fin);
    check("done_laden", DatenGeladen, m_kind == K_LOAD && m_fin);
    check("done_speichern", DatenGespeichert, m_kind == K_STORE && m_fin);
    check("adresse", SpeicherAdresse, m_adr);
    check("befehl", Befehl, m_befehl);
    check("lesewert", DatenLesewert, m_lese);
    check("zeitfehler", Zeitfehler, m_zeit);
    if (m_kind == K_STORE && !m_fin) check("schreibwert", SpeicherSchreibwert, m_wd);
  end

  // Memory responder: SpeicherBereit after mem_wait wait cycles of a strobe (-1 = never).
  int mem_wait  = 0;
  int mem_cnt   = 0;
  bit mem_force = 0;
  initial forever begin
    @(posedge Clock); #1;
    if (mem_force) SpeicherBereit = 1'b1;
    else if (SpeicherLesen || SpeicherSchreiben) begin
      SpeicherBereit = (mem_wait >= 0) && (mem_cnt == mem_wait);
      mem_cnt++;
    end else begin
      SpeicherBereit = 1'b0;
      mem_cnt = 0;
    end
  end

  task automatic tick();
    @(posedge Clock); #1;
  endtask

  // Acts like the control FSM: raise a request, hold it through the done pulse, drop it the cycle after.
  task automatic txn(input bit f, input bit rd, input bit wr, input logic [31:0] adr,
                     input logic [31:0] wd, output int n_rd, output int n_wr,
                     output int n_f, output int n_l, output int n_s, output logic [31:0] adr_seen);
    bit done;
    n_rd = 0; n_wr = 0; n_f = 0; n_l = 0; n_s = 0; adr_seen = '0; done = 0;
    BefehlAnfrage = f; DatenLesen = rd; DatenSchreiben = wr;
    if (f) BefehlAdresse = adr; else DatenAdresse = adr;
    DatenSchreibwert = wd;
    for (int i = 0; i < 40 && !done; i++) begin
      tick();
      if ((SpeicherLesen || SpeicherSchreiben) && n_rd == 0 && n_wr == 0) adr_seen = SpeicherAdresse;
      n_rd += int'(SpeicherLesen);
      n_wr += int'(SpeicherSchreiben);
      n_f  += int'(BefehlGeladen);
      n_l  += int'(DatenGeladen);
      n_s  += int'(DatenGespeichert);
      done = BefehlGeladen || DatenGeladen || DatenGespeichert;
    end
    if (!done) check("txn_completes", 0, 1);
    tick();
    BefehlAnfrage = 0; DatenLesen = 0; DatenSchreiben = 0;
    tick();
  endtask

  int n_rd, n_wr, n_f, n_l, n_s;
  logic [31:0] adr_seen;
  int dones;
  int gseq[$];
  int gcyc[$];

  initial begin
    repeat (3) tick();
    check("rst_zeitfehler", Zeitfehler, 0);
    check("rst_adresse", SpeicherAdresse, 0);
    check("rst_strobes", {SpeicherLesen, SpeicherSchreiben}, 0);
    Reset = 0;
    tick();

    // Minimum-latency fetch, cycle by cycle.
    mem_wait = 0; SpeicherLesewert = 32'hDEADBEEF;
    BefehlAdresse = 32'h100; BefehlAnfrage = 1;
    tick();
    check("f1_lesen", SpeicherLesen, 1);
    check("f1_adresse", SpeicherAdresse, 32'h100);
    check("f1_no_done_c1", BefehlGeladen, 0);
    tick();
    check("f1_done_c2", BefehlGeladen, 1);
    check("f1_befehl", Befehl, 32'hDEADBEEF);
    tick();
    BefehlAnfrage = 0;
    check("f1_no_done_c3", BefehlGeladen, 0);
    tick();

    // Store with three wait cycles.
    mem_wait = 3;
    txn(0, 0, 1, 32'h20, 32'h55, n_rd, n_wr, n_f, n_l, n_s, adr_seen);
    check("st_wr_cycles", n_wr, 4);
    check("st_rd_cycles", n_rd, 0);
    check("st_done", n_s, 1);
    check("st_adresse", adr_seen, 32'h20);

    // Load answered in the cycle the timeout would fire: normal completion.
    SpeicherLesewert = 32'h12345678;
    txn(0, 1, 0, 32'h44, 32'h0, n_rd, n_wr, n_f, n_l, n_s, adr_seen);
    check("ld_edge_rd_cycles", n_rd, 4);
    check("ld_edge_done", n_l, 1);
    check("ld_edge_wert", DatenLesewert, 32'h12345678);
    check("ld_edge_no_zeit", Zeitfehler, 0);

    // Load and store together count as a store.
    mem_wait = 1;
    txn(0, 1, 1, 32'h48, 32'hA5A5, n_rd, n_wr, n_f, n_l, n_s, adr_seen);
    check("ls_store_done", n_s, 1);
    check("ls_no_load_done", n_l, 0);
    check("ls_wr_cycles", n_wr, 2);

    // SpeicherBereit while idle must not start or complete anything.
    mem_force = 1;
    repeat (4) tick();
    check("idle_bereit_strobes", {SpeicherLesen, SpeicherSchreiben}, 0);
    SpeicherLesewert = 32'hCAFE0001;
    txn(1, 0, 0, 32'h200, 32'h0, n_rd, n_wr, n_f, n_l, n_s, adr_seen);
    check("force_rd_cycles", n_rd, 1);
    check("force_befehl", Befehl, 32'hCAFE0001);
    mem_force = 0;
    tick();

    // Timeout on a load, then a normal fetch.
    mem_wait = -1;
    txn(0, 1, 0, 32'h60, 32'h0, n_rd, n_wr, n_f, n_l, n_s, adr_seen);
    check("to_rd_cycles", n_rd, TO);
    check("to_done", n_l, 1);
    check("to_wert_zero", DatenLesewert, 0);
    check("to_zeitfehler", Zeitfehler, 1);
    mem_wait = 0; SpeicherLesewert = 32'h0BADF00D;
    txn(1, 0, 0, 32'h300, 32'h0, n_rd, n_wr, n_f, n_l, n_s, adr_seen);
    check("to_fetch_done", n_f, 1);
    check("to_fetch_befehl", Befehl, 32'h0BADF00D);
    check("to_zeit_sticky", Zeitfehler, 1);

    // Asynchronous reset in the middle of a store.
    mem_wait = -1;
    DatenAdresse = 32'h70; DatenSchreibwert = 32'h77; DatenSchreiben = 1;
    tick();
    tick();
    check("ar_strobe_before", SpeicherSchreiben, 1);
    #2 Reset = 1;
    #1;
    check("ar_strobe_dropped", SpeicherSchreiben, 0);
    DatenSchreiben = 0;
    tick();
    Reset = 0;
    dones = 0;
    repeat (4) begin
      tick();
      dones += int'(BefehlGeladen) + int'(DatenGeladen) + int'(DatenGespeichert);
    end
    check("ar_no_done", dones, 0);
    check("ar_zeit_cleared", Zeitfehler, 0);

    // Both ports requesting continuously right after reset: alternate, fetch first.
    mem_wait = 0; SpeicherLesewert = 32'h600D;
    BefehlAdresse = 32'h400; DatenAdresse = 32'h80;
    BefehlAnfrage = 1; DatenLesen = 1;
    for (int c = 0; c < 14; c++) begin
      tick();
      if (BefehlGeladen) begin gseq.push_back(0); gcyc.push_back(c); end
      if (DatenGeladen)  begin gseq.push_back(1); gcyc.push_back(c); end
    end
    BefehlAnfrage = 0; DatenLesen = 0;
    repeat (6) tick();
    check("rr_count_ge4", gseq.size() >= 4, 1);
    for (int k = 0; k < 4 && k < gseq.size(); k++) check("rr_order", gseq[k], k % 2);
    for (int k = 1; k < 4 && k < gcyc.size(); k++) check("rr_spacing", gcyc[k] - gcyc[k-1], 3);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/speicher_arbiter.md
Name: speicher_arbiter

Overview:
- Shares the single memory bus between the processor's instruction-fetch port and its data load/store port.
- The control FSM drives the requests as level signals held until the done pulse:
  - instruction request from the FETCH state;
  - data load/store requests from the WRITEBACK_LOAD / WRITEBACK_STORE states.
- The arbiter grants one request at a time with round-robin fairness, latches address/data, runs a single-transaction memory handshake with a timeout, and returns a one-cycle done pulse to the control FSM.

Parameters:
- ADRESS_BREITE, 32, address width.
- DATEN_BREITE, 32, data width.
- TIMEOUT, 255, wait cycles without SpeicherBereit before abort; 0 disables the timeout.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- BefehlAnfrage  in  1  instruction fetch request (level).
- BefehlAdresse  in  ADRESS_BREITE  fetch address.
- Befehl  out  DATEN_BREITE  fetched word (registered).
- BefehlGeladen  out  1  fetch done, 1-cycle pulse.
- DatenLesen  in  1  data load request (level).
- DatenSchreiben  in  1  data store request (level).
- DatenAdresse  in  ADRESS_BREITE  load/store address.
- DatenSchreibwert  in  DATEN_BREITE  store data.
- DatenLesewert  out  DATEN_BREITE  loaded word (registered).
- DatenGeladen  out  1  load done, 1-cycle pulse.
- DatenGespeichert  out  1  store done, 1-cycle pulse.
- SpeicherAdresse  out  ADRESS_BREITE  memory address (registered).
- SpeicherSchreibwert  out  DATEN_BREITE  memory write data (registered).
- SpeicherLesen  out  1  memory read strobe.
- SpeicherSchreiben  out  1  memory write strobe.
- SpeicherLesewert  in  DATEN_BREITE  memory read data, valid while SpeicherBereit=1.
- SpeicherBereit  in  1  memory completes the current access this cycle.
- Zeitfehler  out  1  sticky timeout flag.

Behaviour:
- Reset (asynchronous, any cycle, including mid-transaction):
  - state=IDLE; all outputs 0; last-grant register = DATEN, so the instruction port wins the first tie.
  - Timeout counter=0; Zeitfehler=0.
  - Strobes drop immediately, without waiting for a clock edge.
- States: IDLE, BEFEHL, LESEN, SCHREIBEN, ABSCHLUSS.
- IDLE:
  - Instruction request only -> BEFEHL.
  - Data request only -> SCHREIBEN if DatenSchreiben, else LESEN.
  - DatenLesen and DatenSchreiben both high -> treated as a store.
  - Both ports requesting -> grant the port that was NOT granted last; update the last-grant register.
  - On the grant edge, latch address and write data into SpeicherAdresse/SpeicherSchreibwert; clear the timeout counter.
- BEFEHL / LESEN:
  - SpeicherLesen=1 (combinational from state).
  - SCHREIBEN: SpeicherSchreiben=1.
  - Strobes are never both high.
- Grant state with SpeicherBereit=1 at a clock edge:
  - Capture SpeicherLesewert into Befehl (BEFEHL) or DatenLesewert (LESEN).
  - Next state ABSCHLUSS.
- Grant state with SpeicherBereit=0 and TIMEOUT>0:
  - Counter increments each cycle.
  - After TIMEOUT wait cycles: next state ABSCHLUSS, read target loaded with 0, Zeitfehler set (cleared only by Reset).
  - SpeicherBereit in the same cycle the timeout would fire -> normal completion; Zeitfehler not set.
- ABSCHLUSS (exactly 1 cycle):
  - Exactly one done pulse, selected by the latched source: BefehlGeladen, DatenGeladen or DatenGespeichert.
  - Requests are ignored this cycle (the control FSM drops its request on the following cycle).
  - Next state IDLE.
- Latency: request seen in IDLE at cycle 0, strobe in cycle 1, SpeicherBereit in cycle 1 -> done pulse in cycle 2, IDLE in cycle 3. Minimum 3 cycles per transaction.
- Read-data outputs hold their value until the next completion of the same port.
- Request dropped while granted: the transaction still completes and pulses done (no abort path).
- SpeicherBereit outside a grant state is ignored.

Test Plan:
- Reset, then BefehlAnfrage=1, BefehlAdresse=0x100, SpeicherBereit=1 in the first strobe cycle -> SpeicherLesen=1 with SpeicherAdresse=0x100 in cycle 1; BefehlGeladen=1 in cycle 2 only; Befehl=SpeicherLesewert (0xDEADBEEF).
- DatenSchreiben=1, DatenAdresse=0x20, DatenSchreibwert=0x55, SpeicherBereit after 3 wait cycles -> SpeicherSchreiben high for 4 cycles; DatenGespeichert pulses once; SpeicherLesen stays 0.
- Both ports requesting continuously from reset -> grants alternate BEFEHL, LESEN, BEFEHL, LESEN; each done pulse is separated by at least one IDLE cycle.
- TIMEOUT=4, DatenLesen=1, SpeicherBereit never asserted -> after 4 wait cycles DatenGeladen=1 with DatenLesewert=0, Zeitfehler=1 and stays 1; a following fetch completes normally.
- Reset asserted mid-cycle during SCHREIBEN -> SpeicherSchreiben=0 immediately without a clock edge, no done pulse, state IDLE after release.
- DatenLesen=DatenSchreiben=1 together -> store performed; DatenGespeichert pulses, DatenGeladen stays 0.
